imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's PC-addressed instruction requests over a valid/ready handshake with fixed, parameterised read latency. It holds the program image in a word-addressed array and returns each instruction tagged with its PC, in request order. It supports up to DEPTH outstanding requests and a single-cycle flush for branch redirects, so fetch can keep issuing while older responses drain.

---
 rtl/imem_responder.sv | 159 +++++++++++++++
 tb/tb_imem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: PC-addressed fetch requests in, in-order
// instruction responses out after a fixed read latency, with flush support.
module imem_responder #(
   parameter int N       = 32,
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [N-1:0]      req_addr,
   input  logic              flush,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N-1:0]      resp_inst,
   output logic [N-1:0]      resp_pc,
   output logic              resp_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [N-1:0]      ld_data
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   // Program image
   logic [N-1:0] mem_q [2**ADDR_W];

   // Read pipeline, one entry per latency stage
   logic [LATENCY-1:0] pvalid_q;
   logic [LATENCY-1:0] perr_q;
   logic [N-1:0]       pinst_q [LATENCY];
   logic [N-1:0]       ppc_q   [LATENCY];

   // In-order output FIFO
   logic [N-1:0]       finst_q [DEPTH];
   logic [N-1:0]       fpc_q   [DEPTH];
   logic [DEPTH-1:0]   ferr_q;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fcnt_q, fcnt_d;

   logic [CNT_W-1:0]   outstanding_q, outstanding_d;

   logic [ADDR_W-1:0]  req_idx;
   logic               req_err;
   logic               accept;
   logic               push;
   logic               pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign req_idx   = req_addr[ADDR_W+1:2];
   assign req_err   = (req_addr[1:0] != 2'b00) || (|req_addr[N-1:ADDR_W+2]);
   // Depends only on the credit count and flush, never on req_valid/resp_ready.
   assign req_ready = (outstanding_q < DEPTH_C) || flush;
   assign accept    = req_valid && req_ready;

   // A flushed pipeline exit is dropped instead of entering the FIFO.
   assign push = pvalid_q[LATENCY-1] && !flush;
   assign pop  = resp_valid && resp_ready;

   // NOTE: the array has no reset; clearing it would block RAM inference and
   // the loaded program image must survive rst_n.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the pre-edge value of the stage before it; this also gives
   // old-data semantics when a load and a read hit the same word on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pvalid_q <= '0;
         perr_q   <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            pinst_q[k] <= '0;
            ppc_q[k]   <= '0;
         end
      end else begin
         pvalid_q[0] <= accept;
         if (accept) begin
            pinst_q[0] <= req_err ? '0 : mem_q[req_idx];
            ppc_q[0]   <= req_addr;
            perr_q[0]  <= req_err;
         end
         for (int k = 1; k < LATENCY; k++) begin
            pvalid_q[k] <= pvalid_q[k-1] && !flush;
            pinst_q[k]  <= pinst_q[k-1];
            ppc_q[k]    <= ppc_q[k-1];
            perr_q[k]   <= perr_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         finst_q[wr_ptr_q] <= pinst_q[LATENCY-1];
         fpc_q[wr_ptr_q]   <= ppc_q[LATENCY-1];
         ferr_q[wr_ptr_q]  <= perr_q[LATENCY-1];
      end
   end

   // NOTE: every next-state signal gets its default first, so no path through
   // this block can leave one unassigned and infer a latch.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fcnt_d        = fcnt_q;
      outstanding_d = outstanding_q;
      if (flush) begin
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         fcnt_d        = '0;
         outstanding_d = accept ? CNT_W'(1) : '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
            default: fcnt_d = fcnt_q;
         endcase
         case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fcnt_q        <= '0;
         outstanding_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fcnt_q        <= fcnt_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign resp_valid = (fcnt_q != '0);
   assign resp_inst  = resp_valid ? finst_q[rd_ptr_q] : '0;
   assign resp_pc    = resp_valid ? fpc_q[rd_ptr_q]   : '0;
   assign resp_err   = resp_valid && ferr_q[rd_ptr_q];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: each accepted request queues its
// expected response and due cycle; outputs are checked every cycle.
module tb_imem_responder;

   localparam int N       = 32;
   localparam int ADDR_W  = 12;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   typedef struct {
      logic [N-1:0] pc;
      logic [N-1:0] inst;
      logic         err;
      int           due;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [N-1:0]      req_addr;
   logic              flush;
   logic              resp_valid;
   logic              resp_ready;
   logic [N-1:0]      resp_inst;
   logic [N-1:0]      resp_pc;
   logic              resp_err;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [N-1:0]      ld_data;

   exp_t         sb[$];
   logic [N-1:0] tb_mem [2**ADDR_W];
   int           out_m = 0;
   int           cyc   = 0;
   int           total = 0;
   int           bad   = 0;

   imem_responder #(.N(N), .ADDR_W(ADDR_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_inst (resp_inst),
      .resp_pc   (resp_pc),
      .resp_err  (resp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Called at a falling edge with inputs already driven; checks outputs,
   // advances the model across the next rising edge.
   task automatic step(output bit acc);
      bit   exp_valid, exp_ready, hs;
      exp_t e;
      exp_valid = (sb.size() != 0) && (sb[0].due <= cyc);
      exp_ready = (out_m < DEPTH) || flush;
      check("resp_valid", N'(resp_valid), N'(exp_valid));
      check("req_ready", N'(req_ready), N'(exp_ready));
      if (exp_valid) begin
         check("resp_inst", resp_inst, sb[0].inst);
         check("resp_pc", resp_pc, sb[0].pc);
         check("resp_err", N'(resp_err), N'(sb[0].err));
      end
      acc = req_valid && exp_ready;
      hs  = exp_valid && resp_ready;
      e.pc   = req_addr;
      e.err  = (req_addr[1:0] != 2'b00) || (req_addr[N-1:ADDR_W+2] != '0);
      e.inst = e.err ? '0 : tb_mem[req_addr[ADDR_W+1:2]];
      e.due  = cyc + 1 + LATENCY;
      if (flush) sb.delete();
      else if (hs) void'(sb.pop_front());
      if (acc) sb.push_back(e);
      out_m = flush ? int'(acc) : out_m + int'(acc) - int'(hs);
      if (ld_en) tb_mem[ld_addr] = ld_data;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      bit a;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 32 && sb.size() != 0; i++) step(a);
      step(a);
   endtask

   initial begin
      bit a;
      int n_acc;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
      resp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      #1;
      check("rst_req_ready", N'(req_ready), N'(1));
      repeat (2) @(negedge clk);
      check("rst_resp_valid", N'(resp_valid), N'(0));
      check("rst_resp_inst", resp_inst, '0);
      check("rst_resp_pc", resp_pc, '0);
      check("rst_resp_err", N'(resp_err), N'(0));
      rst_n = 1'b1;

      // Program load: words 0..3 from the plan, 4..7 distinct fillers.
      for (int i = 0; i < 8; i++) begin
         ld_en   = 1'b1;
         ld_addr = ADDR_W'(i);
         ld_data = (i < 4) ? N'(32'h11111111 * (i + 1)) : N'(32'hA0000000 + i);
         step(a);
      end
      ld_en = 1'b0;

      // Back-to-back fetch with resp_ready held high.
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = N'(4 * i);
         step(a);
      end
      drain();

      // Back-pressure: exactly DEPTH accepts, then one handshake frees a slot.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      n_acc      = 0;
      for (int i = 0; i < 6; i++) begin
         req_addr = N'(4 * n_acc);
         if (req_valid && req_ready) n_acc++;
         step(a);
      end
      check("bp_accepts", N'(n_acc), N'(DEPTH));
      check("bp_ready_low", N'(req_ready), N'(0));
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      step(a);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 32'h10;
      check("bp_ready_back", N'(req_ready), N'(1));
      step(a);
      step(a);
      drain();

      // Flush with a redirect request in the same cycle.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr = 32'h0; step(a);
      req_addr = 32'h4; step(a);
      req_addr = 32'h8; step(a);
      req_addr = 32'h40; flush = 1'b1; step(a);
      flush     = 1'b0;
      req_valid = 1'b0;
      step(a);
      drain();
      check("flush_credit_free", N'(req_ready), N'(1));

      // Misaligned and out-of-range requests, followed by a good one.
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr = 32'h2;    step(a);
      req_addr = 32'h4000; step(a);
      req_addr = 32'h8;    step(a);
      drain();

      // Load and read of the same word on one edge returns the old word.
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 32'h14;
      ld_en      = 1'b1;
      ld_addr    = ADDR_W'(5);
      ld_data    = 32'hDEADBEEF;
      step(a);
      ld_en = 1'b0;
      step(a);
      drain();

      // Asynchronous reset with three requests outstanding.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr = N'(4 * i);
         step(a);
      end
      req_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("mid_rst_resp_valid", N'(resp_valid), N'(0));
      check("mid_rst_req_ready", N'(req_ready), N'(1));
      sb.delete();
      out_m = 0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst_n      = 1'b1;
      resp_ready = 1'b1;
      repeat (6) step(a);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
